// File: rtl/alu_op_queue.sv
// Operand issue queue in front of the ALU: buffers {R, S, ctl_f, ctl_e} requests, issues
// them one per cycle from registered outputs and tracks when each ALU result becomes valid.
module alu_op_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned W       = 24,
    localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_R,
    input  logic [W-1:0]  in_S,
    input  logic          in_ctl_f,
    input  logic          in_ctl_e,
    input  logic          hold,
    input  logic          flush,
    output logic [W-1:0]  R,
    output logic [W-1:0]  S,
    output logic          ctl_f,
    output logic          ctl_e,
    output logic          issue_valid,
    output logic          res_valid,
    output logic [LW-1:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = 2 * W + 2;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [W-1:0]       r_q, r_d;
    logic [W-1:0]       s_q, s_d;
    logic               ctl_f_q, ctl_f_d;
    logic               ctl_e_q, ctl_e_d;
    logic               issue_valid_q, issue_valid_d;
    logic [ALU_LAT-1:0] res_pipe_q, res_pipe_d;

    logic          full, empty, push, pop;
    logic [W-1:0]  r_canon, s_canon;

    // -0 is folded to +0 so the ALU never sees a negative zero operand.
    always_comb begin
        r_canon = (in_R[W-2:0] == '0) ? '0 : in_R;
        s_canon = (in_S[W-2:0] == '0) ? '0 : in_S;
    end

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        in_ready = rst && !full && !flush;
        push     = in_valid && in_ready;
        pop      = !empty && !hold && !flush;
    end

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        r_d           = r_q;
        s_d           = s_q;
        ctl_f_d       = ctl_f_q;
        ctl_e_d       = ctl_e_q;
        issue_valid_d = 1'b0;
        res_pipe_d    = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {r_canon, s_canon, in_ctl_f, in_ctl_e};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                {r_d, s_d, ctl_f_d, ctl_e_d} = mem_q[rd_ptr_q];
                rd_ptr_d                     = rd_ptr_q + PW'(1);
            end
            issue_valid_d = pop;
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
            res_pipe_d[0] = issue_valid_q;
            for (int i = 1; i < int'(ALU_LAT); i++) begin
                res_pipe_d[i] = res_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            r_q           <= '0;
            s_q           <= '0;
            ctl_f_q       <= 1'b0;
            ctl_e_q       <= 1'b0;
            issue_valid_q <= 1'b0;
            res_pipe_q    <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            r_q           <= r_d;
            s_q           <= s_d;
            ctl_f_q       <= ctl_f_d;
            ctl_e_q       <= ctl_e_d;
            issue_valid_q <= issue_valid_d;
            res_pipe_q    <= res_pipe_d;
        end
    end

    assign R           = r_q;
    assign S           = s_q;
    assign ctl_f       = ctl_f_q;
    assign ctl_e       = ctl_e_q;
    assign issue_valid = issue_valid_q;
    assign res_valid   = res_pipe_q[ALU_LAT-1];
    assign level       = level_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Bench for alu_op_queue: queue-based reference model checked every negedge, plus directed
// scenarios with hand-computed literal expectations.
module tb_alu_op_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned W       = 24;
    localparam int unsigned LW      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic         f;
        logic         e;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_R = '0;
    logic [W-1:0]  in_S = '0;
    logic          in_ctl_f = 1'b0;
    logic          in_ctl_e = 1'b0;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  R, S;
    logic          ctl_f, ctl_e, issue_valid, res_valid;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_R       (in_R),
        .in_S       (in_S),
        .in_ctl_f   (in_ctl_f),
        .in_ctl_e   (in_ctl_e),
        .hold       (hold),
        .flush      (flush),
        .R          (R),
        .S          (S),
        .ctl_f      (ctl_f),
        .ctl_e      (ctl_e),
        .issue_valid(issue_valid),
        .res_valid  (res_valid),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t         mq[$];
    ent_t         m_out;
    bit           m_iv;
    bit           m_hist[$];

    function automatic logic [W-1:0] canon(input logic [W-1:0] v);
        return (v[W-2:0] == '0) ? '0 : v;
    endfunction

    function automatic bit m_res();
        return (m_hist.size() >= ALU_LAT) ? m_hist[ALU_LAT-1] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = '0;
        m_iv  = 1'b0;
        m_hist.delete();
    endtask

    // One rising edge of the specified behaviour, from pre-edge inputs.
    task automatic model_edge();
        bit   do_push, do_pop;
        ent_t e;
        if (!rst) return;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0;
            m_hist.delete();
            return;
        end
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && !hold;
        m_hist.push_front(m_iv);
        if (m_hist.size() > ALU_LAT) void'(m_hist.pop_back());
        if (do_pop) m_out = mq.pop_front();
        m_iv = do_pop;
        if (do_push) begin
            e.r = canon(in_R);
            e.s = canon(in_S);
            e.f = in_ctl_f;
            e.e = in_ctl_e;
            mq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(rst && (mq.size() < DEPTH) && !flush));
        chk("level", 64'(level), 64'(mq.size()));
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        chk("res_valid", 64'(res_valid), 64'(m_res()));
        chk("R", 64'(R), 64'(m_out.r));
        chk("S", 64'(S), 64'(m_out.s));
        chk("ctl", 64'({ctl_f, ctl_e}), 64'({m_out.f, m_out.e}));
    end

    // Drive one cycle of inputs; returns 1 time unit after the edge.
    task automatic cyc(input bit v, input logic [W-1:0] r, input logic [W-1:0] s,
                       input bit f, input bit e, input bit h, input bit fl);
        in_valid = v;
        in_R     = r;
        in_S     = s;
        in_ctl_f = f;
        in_ctl_e = e;
        hold     = h;
        flush    = fl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit h);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, h, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // 1: single push, issue next cycle, result one cycle later
        cyc(1'b1, 24'h00C000, 24'h004000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_level", 64'(level), 64'd1);
        chk("t1_no_issue_yet", 64'(issue_valid), 64'd0);
        idle(1'b0);
        chk("t1_issue", 64'(issue_valid), 64'd1);
        chk("t1_R", 64'(R), 64'h00C000);
        chk("t1_S", 64'(S), 64'h004000);
        chk("t1_ctl_f", 64'(ctl_f), 64'd1);
        chk("t1_res_early", 64'(res_valid), 64'd0);
        idle(1'b0);
        chk("t1_res", 64'(res_valid), 64'd1);
        chk("t1_issue_drop", 64'(issue_valid), 64'd0);
        chk("t1_R_hold", 64'(R), 64'h00C000);

        // 2: fill under hold, fifth push refused, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(i + 1), W'(i + 11), 1'b0, i[0], 1'b1, 1'b0);
        chk("t2_level_full", 64'(level), 64'd4);
        chk("t2_ready_full", 64'(in_ready), 64'd0);
        cyc(1'b1, W'(5), W'(15), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_level_still", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t2_issue", 64'(issue_valid), 64'd1);
            chk("t2_R_order", 64'(R), 64'(i + 1));
        end
        chk("t2_level_empty", 64'(level), 64'd0);
        idle(1'b0);
        chk("t2_no_fifth", 64'(issue_valid), 64'd0);

        // 3: streaming push+pop, pointers wrap
        cyc(1'b1, W'(100), W'(200), 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            cyc(1'b1, W'(100 + i), W'(200 + i), 1'b1, 1'b1, 1'b0, 1'b0);
            chk("t3_level", 64'(level), 64'd1);
            chk("t3_ready", 64'(in_ready), 64'd1);
            chk("t3_R", 64'(R), 64'(100 + i - 1));
        end
        idle(1'b0);
        chk("t3_last_R", 64'(R), 64'd119);
        chk("t3_drained", 64'(level), 64'd0);

        // 4: -0 canonicalised, other negatives untouched
        cyc(1'b1, 24'h800000, 24'h800001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t4_R_negzero", 64'(R), 64'h000000);
        chk("t4_S_neg", 64'(S), 64'h800001);
        idle(1'b0);

        // 5: flush with coincident push
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(50 + i), W'(60 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_filled", 64'(level), 64'd3);
        cyc(1'b1, W'(77), W'(78), 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_issue", 64'(issue_valid), 64'd0);
        chk("t5_res", 64'(res_valid), 64'd0);
        chk("t5_S_kept", 64'(S), 64'h800001);
        idle(1'b0);
        chk("t5_push_dropped", 64'(issue_valid), 64'd0);
        chk("t5_level_after", 64'(level), 64'd0);

        // 6: asynchronous reset mid-stream
        cyc(1'b1, W'(31), W'(32), 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, W'(33), W'(34), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_level", 64'(level), 64'd2);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_level_rst", 64'(level), 64'd0);
        chk("t6_S_rst", 64'(S), 64'd0);
        chk("t6_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("t6_no_issue", 64'(issue_valid), 64'd0);
        end
        cyc(1'b1, 24'h123456, 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t6_new_issue", 64'(issue_valid), 64'd1);
        chk("t6_new_R", 64'(R), 64'h123456);
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
